mii_rx_deframer: RTL
====================

// Module: mii_rx_deframer
// PURPOSE
//  Receive-side counterpart of the MII transmit path: takes PHY_RX/RX_DV nibbles in the PHY_RX_CLOCK
//  domain, strips preamble/SFD and assembles bytes (low nibble first). Streams the bytes to the
//  Ethernet packet parser, checks FCS (CRC-32) and length, and reports frame status at end of frame.
// PARAMETERS
//  MIN_PRE  4     minimum 0x5 preamble nibbles required before SFD nibble 0xD
//  MIN_LEN  64    minimum good frame length in bytes, FCS included
//  MAX_LEN  1518  maximum good frame length in bytes, FCS included
// PORTS
//  rx_clock     in   1   PHY_RX_CLOCK, 2.5/25 MHz
//  reset        in   1   asynchronous, active-high
//  phy_rx       in   4   MII receive nibble
//  rx_dv        in   1   MII receive data valid
//  rx_data      out  8   assembled byte
//  rx_valid     out  1   one-cycle strobe, rx_data valid
//  rx_sop       out  1   with rx_valid on the first byte after SFD (destination MAC byte 0)
//  rx_done      out  1   one-cycle end-of-frame strobe
//  rx_good      out  1   valid with rx_done: CRC ok, length in range, no alignment error
//  rx_len       out  11  valid with rx_done: byte count incl. FCS, saturates at 2047
// BEHAVIOUR
//  Reset: all outputs 0, FSM IDLE, CRC reg 0xFFFFFFFF, counters 0. Async assert; release only on
//   an edge with rx_dv=0, else the FSM remains in DROP until rx_dv=0.
//  Inputs are registered once (s_rx, s_dv); all decisions use the registered values.
//  FSM states:
//   IDLE:   s_dv=1 and s_rx=0x5 -> PRE with pre_cnt=1; s_dv=1 and any other nibble -> DROP.
//   PRE:    s_rx=0x5 -> pre_cnt++ (saturates at 15); s_rx=0xD and pre_cnt>=MIN_PRE -> DATA;
//           any other nibble, or 0xD with pre_cnt<MIN_PRE -> DROP; s_dv=0 -> IDLE (no rx_done).
//   DATA:   alternating phase bit: phase 0 latches low nibble, phase 1 forms {s_rx,low} and the
//           next cycle drives rx_valid=1 with rx_data. Latency: 2 rx_clock from the high nibble
//           at the pins to rx_valid. rx_sop=1 only on the first byte.
//           s_dv=0 -> END.
//   END:    one cycle: rx_done=1; rx_len and rx_good are updated in the same cycle and held
//           until the next rx_done. Next state is IDLE.
//   DROP:   ignores data and produces no strobes; s_dv=0 -> IDLE.
//  CRC: reflected poly 0xEDB88320, init 0xFFFFFFFF, LSB first, updated per byte over all bytes
//   including FCS; residue 0xDEBB20E3 = pass. Two nibble steps per byte are allowed if equivalent.
//  rx_good = crc_pass && MIN_LEN<=rx_len<=MAX_LEN && phase==0 at END (odd nibble count = bad).
//  The dangling odd nibble is discarded and never emitted.
//  Oversize frames keep streaming bytes; rx_len saturates at 2047 with no wrap.
//  Back-to-back frames: a single rx_dv=0 cycle between frames is sufficient; END->IDLE accepts a
//   new preamble on the next cycle.
//  rx_valid/rx_done occur at most once per 2 cycles / once per frame; the consumer has no backpressure.
// TESTING
//  1. 7x0x5+0xD, 64-byte frame with correct FCS -> 64 rx_valid, sop on byte 0, rx_done with rx_good=1,
//     rx_len=64; bytes match, low nibble first.
//  2. Same frame with one payload bit flipped -> rx_good=0, rx_len=64.
//  3. 60-byte frame with correct FCS -> rx_good=0 (runt); 1519-byte frame -> rx_good=0, rx_len=1519.
//  4. Extra nibble before rx_dv falls -> rx_good=0, the extra nibble is not emitted.
//  5. Preamble 0x5,0x5,0xD (MIN_PRE=4) or nibble 0x7 in preamble -> DROP, no rx_valid, no rx_done.
//  6. reset pulsed mid-frame -> outputs 0 at once; remainder dropped; next frame received with
//     rx_good=1.

Source files
------------

// File: rtl/mii_rx_deframer.sv
// MII receive deframer: strips preamble/SFD, assembles bytes low nibble first,
// streams them out, and reports CRC-32 / length / alignment status at end of frame.
//
// state   | meaning
// IDLE    | waiting for rx_dv with a 0x5 preamble nibble
// PRE     | counting 0x5 preamble nibbles, waiting for SFD nibble 0xD
// DATA    | assembling bytes, updating CRC and byte count
// END     | one-cycle end of frame, rx_done/rx_good/rx_len issued
// DROP    | discarding the current burst until rx_dv falls
module mii_rx_deframer #(
   parameter int MIN_PRE = 4,
   parameter int MIN_LEN = 64,
   parameter int MAX_LEN = 1518
) (
   input  logic        rx_clock,
   input  logic        reset,
   input  logic [3:0]  phy_rx,
   input  logic        rx_dv,
   output logic [7:0]  rx_data,
   output logic        rx_valid,
   output logic        rx_sop,
   output logic        rx_done,
   output logic        rx_good,
   output logic [10:0] rx_len
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PRE,
      ST_DATA,
      ST_END,
      ST_DROP
   } state_t;

   localparam logic [3:0]  MIN_PRE_L = 4'(MIN_PRE);
   localparam logic [10:0] MIN_LEN_L = 11'(MIN_LEN);
   localparam logic [10:0] MAX_LEN_L = 11'(MAX_LEN);
   localparam logic [31:0] CRC_POLY  = 32'hEDB8_8320;
   localparam logic [31:0] CRC_INIT  = 32'hFFFF_FFFF;
   localparam logic [31:0] CRC_RES   = 32'hDEBB_20E3;

   state_t      state_q, state_d;
   logic [3:0]  s_rx_q;
   logic        s_dv_q;
   logic        armed_q, armed_d;
   logic [3:0]  pre_cnt_q, pre_cnt_d;
   logic        phase_q, phase_d;
   logic [3:0]  low_q, low_d;
   logic        first_q, first_d;
   logic [31:0] crc_q, crc_d;
   logic [10:0] len_q, len_d;
   logic [7:0]  rx_data_q, rx_data_d;
   logic        rx_valid_q, rx_valid_d;
   logic        rx_sop_q, rx_sop_d;
   logic        rx_done_q, rx_done_d;
   logic        rx_good_q, rx_good_d;
   logic [10:0] rx_len_q, rx_len_d;
   logic [7:0]  byte_w;

   function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] data);
      logic [31:0] r;
      r = crc;
      for (int i = 0; i < 8; i++) begin
         if (r[0] ^ data[i]) r = (r >> 1) ^ CRC_POLY;
         else                r = r >> 1;
      end
      return r;
   endfunction

   assign byte_w = {s_rx_q, low_q};

   always_comb begin
      state_d    = state_q;
      // Arming after reset requires rx_dv low on some edge, so a frame that
      // is already in flight when reset releases is discarded.
      armed_d    = armed_q | ~rx_dv;
      pre_cnt_d  = pre_cnt_q;
      phase_d    = phase_q;
      low_d      = low_q;
      first_d    = first_q;
      crc_d      = crc_q;
      len_d      = len_q;
      rx_data_d  = rx_data_q;
      rx_valid_d = 1'b0;
      rx_sop_d   = 1'b0;
      rx_done_d  = 1'b0;
      rx_good_d  = rx_good_q;
      rx_len_d   = rx_len_q;

      case (state_q)
         // END evaluates the incoming nibble like IDLE so back-to-back frames
         // separated by one idle cycle keep their whole preamble.
         ST_IDLE, ST_END: begin
            if (s_dv_q) begin
               if (armed_q && s_rx_q == 4'h5) begin
                  state_d   = ST_PRE;
                  pre_cnt_d = 4'd1;
               end else begin
                  state_d = ST_DROP;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_PRE: begin
            if (!s_dv_q) begin
               state_d = ST_IDLE;
            end else if (s_rx_q == 4'h5) begin
               pre_cnt_d = (pre_cnt_q == 4'hF) ? pre_cnt_q : pre_cnt_q + 4'd1;
            end else if (s_rx_q == 4'hD && pre_cnt_q >= MIN_PRE_L) begin
               state_d = ST_DATA;
               phase_d = 1'b0;
               first_d = 1'b1;
               crc_d   = CRC_INIT;
               len_d   = 11'd0;
            end else begin
               state_d = ST_DROP;
            end
         end
         ST_DATA: begin
            if (!s_dv_q) begin
               state_d   = ST_END;
               rx_done_d = 1'b1;
               rx_len_d  = len_q;
               rx_good_d = (crc_q == CRC_RES) && (len_q >= MIN_LEN_L) &&
                           (len_q <= MAX_LEN_L) && !phase_q;
            end else if (!phase_q) begin
               low_d   = s_rx_q;
               phase_d = 1'b1;
            end else begin
               rx_data_d  = byte_w;
               rx_valid_d = 1'b1;
               rx_sop_d   = first_q;
               first_d    = 1'b0;
               crc_d      = crc_byte(crc_q, byte_w);
               len_d      = (len_q == 11'h7FF) ? len_q : len_q + 11'd1;
               phase_d    = 1'b0;
            end
         end
         ST_DROP: begin
            if (!s_dv_q) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge rx_clock or posedge reset) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         s_rx_q     <= 4'h0;
         s_dv_q     <= 1'b0;
         armed_q    <= 1'b0;
         pre_cnt_q  <= 4'd0;
         phase_q    <= 1'b0;
         low_q      <= 4'h0;
         first_q    <= 1'b0;
         crc_q      <= CRC_INIT;
         len_q      <= 11'd0;
         rx_data_q  <= 8'h00;
         rx_valid_q <= 1'b0;
         rx_sop_q   <= 1'b0;
         rx_done_q  <= 1'b0;
         rx_good_q  <= 1'b0;
         rx_len_q   <= 11'd0;
      end else begin
         state_q    <= state_d;
         s_rx_q     <= phy_rx;
         s_dv_q     <= rx_dv;
         armed_q    <= armed_d;
         pre_cnt_q  <= pre_cnt_d;
         phase_q    <= phase_d;
         low_q      <= low_d;
         first_q    <= first_d;
         crc_q      <= crc_d;
         len_q      <= len_d;
         rx_data_q  <= rx_data_d;
         rx_valid_q <= rx_valid_d;
         rx_sop_q   <= rx_sop_d;
         rx_done_q  <= rx_done_d;
         rx_good_q  <= rx_good_d;
         rx_len_q   <= rx_len_d;
      end
   end

   assign rx_data  = rx_data_q;
   assign rx_valid = rx_valid_q;
   assign rx_sop   = rx_sop_q;
   assign rx_done  = rx_done_q;
   assign rx_good  = rx_good_q;
   assign rx_len   = rx_len_q;

endmodule
